ppm_word_assembler: RTL
=======================

// Module: ppm_word_assembler
// PURPOSE
//  Parametrised symbol-to-word packer for the PPM decoder back end. Collects decoded
//  SYM_BITS-wide PPM symbols, qualified by the clk16 sample strobe, into WORD_BITS-wide words.
//  Word symbol order is selectable. Finished words go out through a single-entry valid/ready
//  holding register. Adds back-pressure, overflow detection and frame re-alignment.
// PARAMETERS
//  SYM_BITS   2  bits per decoded symbol (2 = 4-PPM, 3 = 8-PPM, 4 = 16-PPM)
//  WORD_BITS  8  output word width; must be an integer multiple of SYM_BITS
//  MSB_FIRST  1  1: first symbol of a word lands in the MSBs; 0: first symbol lands in the LSBs
// PORTS
//  clk        in   1               system clock; all logic on posedge
//  rst        in   1               synchronous reset, active-high
//  clk16      in   1               1/16 sample strobe; qualifies sym_valid
//  sym_valid  in   1               decoded symbol present (finish-of-symbol pulse)
//  sym_in     in   SYM_BITS        decoded symbol value
//  frame_clr  in   1               discard partial word, restart symbol count at 0
//  out_data   out  WORD_BITS       assembled word
//  out_valid  out  1               out_data holds an unconsumed word
//  out_ready  in   1               downstream accepts out_data this cycle
//  sym_cnt    out  clog2(SYMS)+1   symbols held in the current partial word (SYMS = WORD_BITS/SYM_BITS)
//  ovf_err    out  1               sticky: a completed word was dropped
//  clr_err    in   1               clears ovf_err
// BEHAVIOUR
//  - Reset (rst=1 at posedge): shreg, sym_cnt, out_data, out_valid and ovf_err go to 0.
//    Reset has priority over every other input. Reset mid-word discards the partial word.
//  - Accept condition: acc = clk16 & sym_valid. sym_valid without clk16 is ignored.
//  - Shift on acc:
//    MSB_FIRST=1: shreg <= {shreg[WORD_BITS-SYM_BITS-1:0], sym_in}
//    MSB_FIRST=0: shreg <= {sym_in, shreg[WORD_BITS-1:SYM_BITS]}
//  - sym_cnt increments on each acc. On the acc with sym_cnt==SYMS-1, the word completes.
//    On that same edge, sym_cnt wraps to 0 and shreg clears.
//  - Word assembly FSM: {COLLECT}, counter-driven as described above.
//  - Output FSM: EMPTY (out_valid=0) / FULL (out_valid=1).
//    EMPTY -> FULL on completion. out_data = completed word; out_valid rises the cycle after
//    the final symbol edge (latency 1 clk).
//    FULL -> EMPTY on out_valid & out_ready with no completion in the same cycle.
//    FULL with handshake and completion in the same cycle: load the new word, out_valid stays
//    1 (no bubble).
//    FULL without handshake and completion in the same cycle: the new word is dropped,
//    out_data/out_valid are unchanged, ovf_err <= 1.
//  - out_data is stable while out_valid=1 and out_ready=0.
//  - frame_clr: sym_cnt <= 0, shreg <= 0. frame_clr wins over a simultaneous acc (that symbol
//    is discarded, no completion). The output register is unaffected.
//  - ovf_err: sticky until clr_err. If clr_err and a new overflow occur in the same cycle,
//    ovf_err = 1 (set wins).
//  - Widths: sym_cnt never exceeds SYMS-1. No arithmetic is performed on data.
// TESTING
//  1 Defaults; out_ready=1; symbols 3,0,2,1 each with clk16 -> out_data=8'hC9, out_valid high
//    exactly 1 clk after the 4th acc, for 1 cycle.
//  2 MSB_FIRST=0; same symbols -> out_data=8'h63.
//  3 out_ready=0; 8 symbols (two words: 8'hC9 then 8'h1B) -> out_data stays 8'hC9 and
//    ovf_err=1; out_ready=1 -> one transfer of 8'hC9; clr_err -> ovf_err=0.
//  4 out_ready=1; words back-to-back with completion on the handshake cycle -> out_valid
//    stays 1, no bubble, both words transferred in order.
//  5 2 symbols, then frame_clr (with a simultaneous acc), then 3,3,3,3 -> single word 8'hFF,
//    sym_cnt goes 0 after the clear.
//  6 SYM_BITS=4, WORD_BITS=16; sym_valid pulses without clk16 ignored; rst after 2 symbols ->
//    all outputs 0; then A,B,C,D -> 16'hABCD.

Source files
------------

// File: rtl/ppm_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : ppm_word_assembler
// Description : Packs clk16-qualified PPM symbols into words and presents them
//               through a single-entry valid/ready holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module ppm_word_assembler #(
    parameter int SYM_BITS  = 2,
    parameter int WORD_BITS = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    clk16,
    input  logic                                    sym_valid,
    input  logic [SYM_BITS-1:0]                     sym_in,
    input  logic                                    frame_clr,
    output logic [WORD_BITS-1:0]                    out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [$clog2(WORD_BITS/SYM_BITS):0]     sym_cnt,
    output logic                                    ovf_err,
    input  logic                                    clr_err
);

    localparam int             SYMS   = WORD_BITS / SYM_BITS;
    localparam int             CW     = $clog2(SYMS) + 1;
    localparam logic [CW-1:0]  c_LAST = CW'(SYMS - 1);

    localparam logic [0:0]     c_EMPTY = 1'b0;
    localparam logic [0:0]     c_FULL  = 1'b1;

    logic                      w_acc;
    logic                      w_complete;
    logic                      w_drop;
    logic [WORD_BITS-1:0]      w_shifted;
    logic [CW-1:0]             r_cnt;
    logic [0:0]                r_state;
    logic [WORD_BITS-1:0]      r_data;
    logic                      r_ovf;

    assign w_acc      = clk16 & sym_valid;
    assign w_complete = w_acc & ~frame_clr & (r_cnt == c_LAST);
    assign w_drop     = w_complete & (r_state == c_FULL) & ~out_ready;

    // Only the SYMS-1 symbols of a partial word are stored; the final
    // symbol is merged combinationally straight into the output register.
    generate
        if (SYMS == 1) begin : g_single_sym
            assign w_shifted = sym_in;
        end else begin : g_multi_sym
            logic [WORD_BITS-SYM_BITS-1:0] r_part;

            if (MSB_FIRST != 0) begin : g_msb_first
                assign w_shifted = {r_part, sym_in};
            end else begin : g_lsb_first
                assign w_shifted = {sym_in, r_part};
            end

            always_ff @(posedge clk) begin
                if (rst || frame_clr || w_complete) begin
                    r_part <= '0;
                end else if (w_acc) begin
                    if (MSB_FIRST != 0) begin
                        r_part <= w_shifted[WORD_BITS-SYM_BITS-1:0];
                    end else begin
                        r_part <= w_shifted[WORD_BITS-1:SYM_BITS];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || frame_clr) begin
            r_cnt <= '0;
        end else if (w_acc) begin
            r_cnt <= w_complete ? '0 : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_complete) begin
                        r_data  <= w_shifted;
                        r_state <= c_FULL;
                    end
                end
                c_FULL: begin
                    // A completion without a handshake is dropped and flagged.
                    if (w_complete && out_ready) begin
                        r_data <= w_shifted;
                    end else if (!w_complete && out_ready) begin
                        r_state <= c_EMPTY;
                    end
                end
                default: r_state <= c_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_err) begin
            r_ovf <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_valid = (r_state == c_FULL);
    assign sym_cnt   = r_cnt;
    assign ovf_err   = r_ovf;

endmodule
`default_nettype wire
